enemy_spawner: RTL and testbench

Parametrised successor to the fixed-rate enemy-generation trigger. It decides when, and in which lane, the next obstacle appears. Gaps are pseudo-random (LFSR jitter) and shrink with a difficulty level that rises every N accepted spawns. Each spawn request is presented to the game-state updater over a valid/ready handshake. The block runs on the system clock, advances its timing only on the game-step enable `tick` (sourced from the frequency divider), and is instantiated in the LittleDinosaur top.

---
 rtl/enemy_spawner_pkg.sv | 18 +
 rtl/enemy_spawner_lfsr_gen.sv | 42 ++++
 rtl/enemy_spawner.sv | 148 ++++++++++++++
 tb/tb_enemy_spawner.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_spawner_pkg.sv
// rtl/enemy_spawner_pkg.sv - shared state codes, defaults and width helper for the enemy spawner
package enemy_spawner_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_OFFER = 2'd2
    } spawn_state_e;

    // Defaults shared with the game-state and render logic.
    localparam int DEF_LEVEL_MAX = 5;
    localparam int DEF_LANES     = 2;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/enemy_spawner_lfsr_gen.sv
// rtl/enemy_spawner_lfsr_gen.sv - right-shifting Galois LFSR with zero-lock guard
module lfsr_gen #(
    parameter int             W    = 16,
    parameter logic [W-1:0]   TAPS = 16'hB400,
    parameter logic [W-1:0]   SEED = 16'hACE1
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] q
);

    // An all-zero state would lock the register, so it is replaced by 1.
    localparam logic [W-1:0] INIT = (SEED == '0) ? {{(W-1){1'b0}}, 1'b1} : SEED;

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = q_q >> 1;
            if (q_q[0]) begin
                q_d = q_d ^ TAPS;
            end
            if (q_d == '0) begin
                q_d = INIT;
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            q_q <= INIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/enemy_spawner.sv
// rtl/enemy_spawner.sv - obstacle spawn scheduler with LFSR-jittered gaps and rising difficulty
module enemy_spawner
    import enemy_spawner_pkg::*;
#(
    parameter int                  LANES         = DEF_LANES,
    parameter int                  LFSR_W        = 16,
    parameter logic [LFSR_W-1:0]   LFSR_TAPS     = 16'hB400,
    parameter logic [LFSR_W-1:0]   SEED          = 16'hACE1,
    parameter int                  GAP_MIN       = 20,
    parameter int                  JIT_W         = 5,
    parameter int                  JITTER_EN     = 1,
    parameter int                  SPEEDUP_EVERY = 8,
    parameter int                  LEVEL_MAX     = DEF_LEVEL_MAX,
    localparam int                 LANE_W        = width_of(LANES),
    localparam int                 LVL_W         = width_of(LEVEL_MAX + 1)
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              tick,
    input  logic              run,
    output logic              spawn_valid,
    input  logic              spawn_ready,
    output logic [LANE_W-1:0] spawn_lane,
    output logic [LVL_W-1:0]  level
);

    localparam int CNT_W = width_of(GAP_MIN + 2 ** JIT_W);
    localparam int SPD_W = width_of(SPEEDUP_EVERY);

    spawn_state_e      state_q, state_d;
    logic [CNT_W-1:0]  gap_q, gap_d;
    logic [LVL_W-1:0]  level_q, level_d, lvl_next;
    logic [SPD_W-1:0]  spd_q, spd_d, spd_next;
    logic              valid_q, valid_d;
    logic [LANE_W-1:0] lane_q, lane_d, lane_r, lane_map;
    logic [JIT_W-1:0]  rnd;
    logic [LFSR_W-1:0] lfsr;
    logic              lfsr_unused;

    lfsr_gen #(
        .W    (LFSR_W),
        .TAPS (LFSR_TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clock (clock),
        .rst   (rst),
        .en    (run),
        .q     (lfsr)
    );

    assign lfsr_unused = ^lfsr;
    assign rnd         = (JITTER_EN != 0) ? lfsr[JIT_W-1:0] : '0;
    assign lane_r      = lfsr[LANE_W-1:0];

    // Fold out-of-range lane codes back into range; the resulting bias is acceptable.
    always_comb begin
        lane_map = lane_r;
        if (int'(lane_r) >= LANES) begin
            lane_map = LANE_W'(int'(lane_r) - LANES);
        end
    end

    function automatic logic [CNT_W-1:0] gap_for(input logic [JIT_W-1:0] r,
                                                 input logic [LVL_W-1:0] lvl);
        logic [JIT_W-1:0] ext;
        ext = r >> lvl;
        return CNT_W'(GAP_MIN) + CNT_W'(ext);
    endfunction

    always_comb begin
        spd_next = spd_q + SPD_W'(1);
        lvl_next = level_q;
        if (spd_q == SPD_W'(SPEEDUP_EVERY - 1)) begin
            spd_next = '0;
            if (level_q != LVL_W'(LEVEL_MAX)) begin
                lvl_next = level_q + LVL_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        level_d = level_q;
        spd_d   = spd_q;
        valid_d = valid_q;
        lane_d  = lane_q;
        if (!run) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_WAIT;
                    level_d = '0;
                    spd_d   = '0;
                    gap_d   = gap_for(rnd, '0);
                end
                S_WAIT: begin
                    if (tick) begin
                        if (gap_q <= CNT_W'(1)) begin
                            state_d = S_OFFER;
                            valid_d = 1'b1;
                            lane_d  = lane_map;
                            gap_d   = '0;
                        end else begin
                            gap_d = gap_q - CNT_W'(1);
                        end
                    end
                end
                S_OFFER: begin
                    // tick is deliberately ignored here; only the handshake moves on.
                    if (spawn_ready) begin
                        state_d = S_WAIT;
                        valid_d = 1'b0;
                        level_d = lvl_next;
                        spd_d   = spd_next;
                        gap_d   = gap_for(rnd, lvl_next);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            level_q <= '0;
            spd_q   <= '0;
            valid_q <= 1'b0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            level_q <= level_d;
            spd_q   <= spd_d;
            valid_q <= valid_d;
            lane_q  <= lane_d;
        end
    end

    assign spawn_valid = valid_q;
    assign spawn_lane  = lane_q;
    assign level       = level_q;

endmodule

// File: tb/tb_enemy_spawner.sv
// tb/tb_enemy_spawner.sv - scoreboard bench for enemy_spawner
module tb_enemy_spawner;
    import enemy_spawner_pkg::*;

    typedef struct {
        int level;
        int wait_c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b1;

    logic       run_d = 1'b0, ready_d = 1'b1, valid_d;
    logic [0:0] lane_d;
    logic [2:0] level_d;

    logic       run_j = 1'b0, ready_j = 1'b1, valid_j;
    logic [1:0] lane_j;
    logic [2:0] level_j;

    logic       run_s = 1'b0, ready_s = 1'b1, valid_s;
    logic [0:0] lane_s;
    logic [2:0] level_s;

    int tests = 0;
    int fails = 0;

    exp_t sb_q[$];
    int   hs_d = 0, wait_d = 0;
    logic pv_d = 1'b0;
    logic exp_lane = 1'b0;
    logic [15:0] m_lfsr = 16'hACE1, m_prev = 16'hACE1;

    int   hs_j = 0, wait_j = 0;
    logic pv_j = 1'b0, first_j = 1'b1;
    int   seen_j [3] = '{0, 0, 0};

    int hs_s = 0, zeros_s = 0;

    always #5 clk = ~clk;

    enemy_spawner #(.LANES(2), .GAP_MIN(4), .JITTER_EN(0)) dut_d (
        .clock(clk), .rst(rst), .tick(tick), .run(run_d), .spawn_valid(valid_d),
        .spawn_ready(ready_d), .spawn_lane(lane_d), .level(level_d));

    enemy_spawner #(.LANES(3), .GAP_MIN(20), .JITTER_EN(1), .SPEEDUP_EVERY(64)) dut_j (
        .clock(clk), .rst(rst), .tick(tick), .run(run_j), .spawn_valid(valid_j),
        .spawn_ready(ready_j), .spawn_lane(lane_j), .level(level_j));

    enemy_spawner #(.LANES(2), .SEED(16'h0000), .GAP_MIN(2), .JITTER_EN(0)) dut_s (
        .clock(clk), .rst(rst), .tick(tick), .run(run_s), .spawn_valid(valid_s),
        .spawn_ready(ready_s), .spawn_lane(lane_s), .level(level_s));

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected within [%0d,%0d]", name, act, lo, hi);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic [15:0] y;
        y = {1'b0, x[15:1]};
        if (x[0]) y = y ^ 16'hB400;
        return y;
    endfunction

    // Spawn k of a run offers at level min(k/8,5); the first one after run rises waits GAP+1 clocks.
    task automatic push_exp(input int k0, input int n, input bit fresh);
        exp_t e;
        for (int k = k0; k < k0 + n; k++) begin
            e.level  = (k / 8 > 5) ? 5 : k / 8;
            e.wait_c = (fresh && k == k0) ? 5 : 4;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_hs(input int target, input string name);
        int n = 0;
        while (hs_d < target && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, hs_d, target);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clk);
        while (!valid_d && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, valid_d, 1);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr = 16'hACE1;
            m_prev = 16'hACE1;
        end else begin
            m_prev = m_lfsr;
            if (run_d) m_lfsr = lfsr_step(m_lfsr);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            wait_d = 0;
            pv_d   = 1'b0;
        end else begin
            if (valid_d && !pv_d) begin
                exp_lane = m_prev[0];
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_spawn: got spawn, expected none");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("spawn_gap", wait_d, e.wait_c);
                    check("spawn_level", level_d, e.level);
                    check("spawn_lane", lane_d, exp_lane);
                end
            end else if (valid_d && pv_d) begin
                check("lane_stable", lane_d, exp_lane);
            end
            if (valid_d && ready_d) begin
                hs_d++;
                wait_d = 0;
            end else if (!valid_d && run_d) begin
                wait_d++;
            end else if (!run_d) begin
                wait_d = 0;
            end
            pv_d = valid_d;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            wait_j  = 0;
            pv_j    = 1'b0;
            first_j = 1'b1;
        end else begin
            if (valid_j && !pv_j) begin
                int lvl;
                int g;
                lvl = (hs_j / 64 > 5) ? 5 : hs_j / 64;
                g   = first_j ? wait_j - 1 : wait_j;
                check_range("jit_gap", g, 20, 20 + (31 >> lvl));
                check("jit_level", level_j, lvl);
                check_range("jit_lane", lane_j, 0, 2);
                if (lane_j < 2'd3) seen_j[lane_j] = 1;
                first_j = 1'b0;
            end
            if (valid_j && ready_j) begin
                hs_j++;
                wait_j = 0;
            end else if (!valid_j && run_j) begin
                wait_j++;
            end
            pv_j = valid_j;
        end
    end

    always @(negedge clk) begin
        if (!rst && run_s) begin
            if (dut_s.u_lfsr.q == 16'h0000) zeros_s++;
            if (valid_s && ready_s) hs_s++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        #9;
        check("rst_valid", valid_d, 0);
        check("rst_lane", lane_d, 0);
        check("rst_level", level_d, 0);
        check("rst_lfsr", dut_d.u_lfsr.q, 16'hACE1);
        check("rst_lfsr_seed0", dut_s.u_lfsr.q, 16'h0001);
        #11 rst = 1'b0;

        push_exp(0, 42, 1'b1);
        @(posedge clk); #1 run_d = 1'b1;
        wait_hs(42, "det_hs42");
        check("det_level_sat", level_d, 5);

        ready_d = 1'b0;
        push_exp(42, 1, 1'b0);
        wait_valid("bp_offer");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_valid", valid_d, 1);
        end
        @(posedge clk); #1 ready_d = 1'b1;
        wait_hs(43, "bp_accept");
        ready_d = 1'b0;
        push_exp(43, 1, 1'b0);
        @(negedge clk);
        check("bp_one_accept", valid_d, 0);

        wait_valid("flush_offer");
        @(posedge clk); #1 run_d = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("flush_valid", valid_d, 0);
        check("flush_state", int'(dut_d.state_q), int'(S_IDLE));
        check("flush_level_held", level_d, 5);

        push_exp(0, 9, 1'b1);
        ready_d = 1'b1;
        @(posedge clk); #1 run_d = 1'b1;
        wait_hs(52, "rerun_hs");
        ready_d = 1'b0;
        check("rerun_level", level_d, 1);
        push_exp(9, 1, 1'b0);
        wait_valid("arst_offer");
        #2 rst = 1'b1;
        #1;
        check("arst_valid", valid_d, 0);
        check("arst_level", level_d, 0);
        check("arst_lane", lane_d, 0);
        run_d = 1'b0;
        #20 rst = 1'b0;
        #1;
        check("arst_lfsr", dut_d.u_lfsr.q, 16'hACE1);
        check("sb_drained", sb_q.size(), 0);

        @(posedge clk); #1 run_j = 1'b1;
        begin
            int n = 0;
            while (hs_j < 340 && n < 20000) begin
                @(posedge clk); #1;
                n++;
            end
        end
        run_j = 1'b0;
        check("jit_hs", hs_j, 340);
        check("jit_level_final", level_j, 5);
        for (int i = 0; i < 3; i++) check($sformatf("jit_lane_seen%0d", i), seen_j[i], 1);

        @(posedge clk); #1 run_s = 1'b1;
        repeat (200) @(posedge clk);
        #1 run_s = 1'b0;
        check_range("seed0_spawns", hs_s, 30, 1000);
        check("seed0_no_zero", zeros_s, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
